// File: rtl/reg_read_stage_if.sv
// rtl/reg_read_stage_if.sv - decode-side and execute-side handshake bundle for the register read stage
interface reg_read_stage_if;
  // decode -> register read
  logic        decValid;
  logic        decReady;
  logic [4:0]  decRs1;
  logic [4:0]  decRs2;
  logic [4:0]  decRd;
  logic        decRdWrite;
  logic [31:0] decPayload;

  // register read -> execute
  logic        exValid;
  logic        exReady;
  logic [31:0] exRs1Value;
  logic [31:0] exRs2Value;
  logic [4:0]  exRd;
  logic        exRdWrite;
  logic [31:0] exPayload;

  // the register read stage itself
  modport slave (
    input  decValid,
    output decReady,
    input  decRs1,
    input  decRs2,
    input  decRd,
    input  decRdWrite,
    input  decPayload,
    output exValid,
    input  exReady,
    output exRs1Value,
    output exRs2Value,
    output exRd,
    output exRdWrite,
    output exPayload
  );

  // the surrounding pipeline (decode producer and execute consumer)
  modport master (
    output decValid,
    input  decReady,
    output decRs1,
    output decRs2,
    output decRd,
    output decRdWrite,
    output decPayload,
    input  exValid,
    output exReady,
    input  exRs1Value,
    input  exRs2Value,
    input  exRd,
    input  exRdWrite,
    input  exPayload
  );
endinterface

// File: rtl/reg_read_stage.sv
// rtl/reg_read_stage.sv - operand fetch with writeback bypass, busy-bit scoreboard and one output register
module reg_read_stage (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  flush,
  reg_read_stage_if.slave       rr,
  output logic [4:0]            regReadAddr1,
  output logic [4:0]            regReadAddr2,
  input  logic [31:0]           regReadValue1,
  input  logic [31:0]           regReadValue2,
  input  logic                  wbWriteEnable,
  input  logic [4:0]            wbWriteAddr,
  input  logic [31:0]           wbWriteValue
);

  // one bit per architectural register: a result is still in flight toward it
  logic [31:0] busy_q, busy_d;

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_rs1_value_q, ex_rs1_value_d;
  logic [31:0] ex_rs2_value_q, ex_rs2_value_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_rd_write_q, ex_rd_write_d;
  logic [31:0] ex_payload_q, ex_payload_d;

  logic        wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  logic [31:0] op1_value, op2_value;
  logic        hazard_rs1, hazard_rs2, hazard_waw;
  logic        out_free;
  logic        dec_ready;
  logic        accept;

  // register file addresses follow the decode sources directly
  assign regReadAddr1 = rr.decRs1;
  assign regReadAddr2 = rr.decRs2;

  // operand selection: x0 reads zero, a same-cycle writeback wins over the stale file value
  always_comb begin
    wb_hit_rs1 = 1'b0;
    wb_hit_rs2 = 1'b0;
    wb_hit_rd  = 1'b0;
    op1_value  = regReadValue1;
    op2_value  = regReadValue2;

    wb_hit_rs1 = wbWriteEnable && (wbWriteAddr == rr.decRs1);
    wb_hit_rs2 = wbWriteEnable && (wbWriteAddr == rr.decRs2);
    wb_hit_rd  = wbWriteEnable && (wbWriteAddr == rr.decRd);

    if (rr.decRs1 == 5'd0) begin
      op1_value = 32'd0;
    end else if (wb_hit_rs1) begin
      op1_value = wbWriteValue;
    end

    if (rr.decRs2 == 5'd0) begin
      op2_value = 32'd0;
    end else if (wb_hit_rs2) begin
      op2_value = wbWriteValue;
    end
  end

  // hazard detection and the ready decision; decValid deliberately does not feed ready
  always_comb begin
    hazard_rs1 = 1'b0;
    hazard_rs2 = 1'b0;
    hazard_waw = 1'b0;
    out_free   = 1'b0;
    dec_ready  = 1'b0;
    accept     = 1'b0;

    // a writeback landing this cycle resolves the dependency, so it is not a hazard
    hazard_rs1 = (rr.decRs1 != 5'd0) && busy_q[rr.decRs1] && !wb_hit_rs1;
    hazard_rs2 = (rr.decRs2 != 5'd0) && busy_q[rr.decRs2] && !wb_hit_rs2;
    hazard_waw = rr.decRdWrite && (rr.decRd != 5'd0) && busy_q[rr.decRd] && !wb_hit_rd;

    out_free  = !ex_valid_q || rr.exReady;
    dec_ready = !flush && out_free && !hazard_rs1 && !hazard_rs2 && !hazard_waw;
    accept    = rr.decValid && dec_ready;
  end

  assign rr.decReady = dec_ready;

  // next state for the scoreboard and the output register
  always_comb begin
    busy_d         = busy_q;
    ex_valid_d     = ex_valid_q;
    ex_rs1_value_d = ex_rs1_value_q;
    ex_rs2_value_d = ex_rs2_value_q;
    ex_rd_d        = ex_rd_q;
    ex_rd_write_d  = ex_rd_write_q;
    ex_payload_d   = ex_payload_q;

    if (flush) begin
      // redirect: everything in flight is dead, including this cycle's writeback bookkeeping
      busy_d     = 32'd0;
      ex_valid_d = 1'b0;
    end else begin
      // clear first so that a simultaneous re-issue to the same register keeps it busy
      if (wbWriteEnable) begin
        busy_d[wbWriteAddr] = 1'b0;
      end
      if (accept && rr.decRdWrite && (rr.decRd != 5'd0)) begin
        busy_d[rr.decRd] = 1'b1;
      end

      if (accept) begin
        ex_valid_d     = 1'b1;
        ex_rs1_value_d = op1_value;
        ex_rs2_value_d = op2_value;
        ex_rd_d        = rr.decRd;
        ex_rd_write_d  = rr.decRdWrite;
        ex_payload_d   = rr.decPayload;
      end else if (ex_valid_q && rr.exReady) begin
        ex_valid_d = 1'b0;
      end
    end

    // x0 is never tracked
    busy_d[0] = 1'b0;
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy_q         <= 32'd0;
      ex_valid_q     <= 1'b0;
      ex_rs1_value_q <= 32'd0;
      ex_rs2_value_q <= 32'd0;
      ex_rd_q        <= 5'd0;
      ex_rd_write_q  <= 1'b0;
      ex_payload_q   <= 32'd0;
    end else begin
      busy_q         <= busy_d;
      ex_valid_q     <= ex_valid_d;
      ex_rs1_value_q <= ex_rs1_value_d;
      ex_rs2_value_q <= ex_rs2_value_d;
      ex_rd_q        <= ex_rd_d;
      ex_rd_write_q  <= ex_rd_write_d;
      ex_payload_q   <= ex_payload_d;
    end
  end

  assign rr.exValid    = ex_valid_q;
  assign rr.exRs1Value = ex_rs1_value_q;
  assign rr.exRs2Value = ex_rs2_value_q;
  assign rr.exRd       = ex_rd_q;
  assign rr.exRdWrite  = ex_rd_write_q;
  assign rr.exPayload  = ex_payload_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// tb/tb_reg_read_stage.sv - table-driven bench with an expected-result queue for reg_read_stage
module tb_reg_read_stage;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic [4:0]  regReadAddr1, regReadAddr2;
  logic [31:0] regReadValue1, regReadValue2;
  logic        wbWriteEnable;
  logic [4:0]  wbWriteAddr;
  logic [31:0] wbWriteValue;

  reg_read_stage_if rr ();

  reg_read_stage dut (
    .clk           (clk),
    .rstN          (rstN),
    .flush         (flush),
    .rr            (rr.slave),
    .regReadAddr1  (regReadAddr1),
    .regReadAddr2  (regReadAddr2),
    .regReadValue1 (regReadValue1),
    .regReadValue2 (regReadValue2),
    .wbWriteEnable (wbWriteEnable),
    .wbWriteAddr   (wbWriteAddr),
    .wbWriteValue  (wbWriteValue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] pl;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbv;
    logic        exr;
    logic        fl;
    logic        exp_ready;
  } vec_t;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] pl;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] m_busy;
  logic        m_exv;
  int          checks;
  int          errors;

  function automatic vec_t mk(logic dv, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic rw, logic [31:0] pl, logic [31:0] rv1, logic [31:0] rv2,
                              logic wbe, logic [4:0] wba, logic [31:0] wbv, logic exr,
                              logic fl, logic exp_ready);
    vec_t v;
    v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw; v.pl = pl;
    v.rv1 = rv1; v.rv2 = rv2; v.wbe = wbe; v.wba = wba; v.wbv = wbv;
    v.exr = exr; v.fl = fl; v.exp_ready = exp_ready;
    return v;
  endfunction

  function automatic logic [31:0] opnd(logic [4:0] rs, logic [31:0] rv, logic wbe,
                                       logic [4:0] wba, logic [31:0] wbv);
    if (rs == 5'd0) return 32'd0;
    if (wbe && (wba == rs)) return wbv;
    return rv;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(vec_t v, bit release_rst);
    exp_t e;
    bit   acc;
    @(negedge clk);
    rr.decValid   = v.dv;
    rr.decRs1     = v.rs1;
    rr.decRs2     = v.rs2;
    rr.decRd      = v.rd;
    rr.decRdWrite = v.rw;
    rr.decPayload = v.pl;
    regReadValue1 = v.rv1;
    regReadValue2 = v.rv2;
    wbWriteEnable = v.wbe;
    wbWriteAddr   = v.wba;
    wbWriteValue  = v.wbv;
    rr.exReady    = v.exr;
    flush         = v.fl;
    if (release_rst) rstN = 1'b1;
    #1;
    chk("decReady", {31'd0, rr.decReady}, {31'd0, v.exp_ready});
    chk("regReadAddr1", {27'd0, regReadAddr1}, {27'd0, v.rs1});
    chk("regReadAddr2", {27'd0, regReadAddr2}, {27'd0, v.rs2});
    chk("exValid", {31'd0, rr.exValid}, {31'd0, m_exv});
    if (m_exv) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: exValid with no expected entry at %0t", $time);
      end else begin
        chk("exRs1Value", rr.exRs1Value, sb[0].op1);
        chk("exRs2Value", rr.exRs2Value, sb[0].op2);
        chk("exRd", {27'd0, rr.exRd}, {27'd0, sb[0].rd});
        chk("exRdWrite", {31'd0, rr.exRdWrite}, {31'd0, sb[0].rw});
        chk("exPayload", rr.exPayload, sb[0].pl);
        if (v.exr) void'(sb.pop_front());
      end
    end
    if (v.fl) begin
      sb.delete();
      m_busy = 32'd0;
      m_exv  = 1'b0;
    end else begin
      acc = v.dv && v.exp_ready;
      if (v.wbe) m_busy[v.wba] = 1'b0;
      if (acc && v.rw && (v.rd != 5'd0)) m_busy[v.rd] = 1'b1;
      if (acc) begin
        e.op1 = opnd(v.rs1, v.rv1, v.wbe, v.wba, v.wbv);
        e.op2 = opnd(v.rs2, v.rv2, v.wbe, v.wba, v.wbv);
        e.rd  = v.rd;
        e.rw  = v.rw;
        e.pl  = v.pl;
        sb.push_back(e);
        m_exv = 1'b1;
      end else if (v.exr) begin
        m_exv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("busy", dut.busy_q, m_busy);
    chk("exValid_next", {31'd0, rr.exValid}, {31'd0, m_exv});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_busy = 32'd0;
    m_exv  = 1'b0;

    //             dv rs1 rs2 rd rw pl            rv1           rv2           wbe wba wbv           exr fl rdy
    vecs.push_back(mk(1, 1, 2, 3, 1, 32'hA000_0000, 32'd5,        32'd7,        0, 0, 32'd0,        1, 0, 1)); // independent issue
    vecs.push_back(mk(1, 3, 0, 4, 1, 32'hA000_0001, 32'd99,       32'hDEAD,     0, 0, 32'd0,        1, 0, 0)); // RAW stall
    vecs.push_back(mk(1, 3, 0, 4, 1, 32'hA000_0001, 32'd99,       32'hDEAD,     0, 0, 32'd0,        1, 0, 0));
    vecs.push_back(mk(1, 3, 0, 4, 1, 32'hA000_0001, 32'd99,       32'hDEAD,     1, 3, 32'h1234,     1, 0, 1)); // resolved by bypass
    vecs.push_back(mk(1, 1, 2, 6, 1, 32'hB000_0000, 32'd11,       32'd22,       0, 0, 32'd0,        0, 0, 0)); // backpressure x4
    vecs.push_back(mk(1, 1, 2, 6, 1, 32'hB000_0000, 32'd11,       32'd22,       0, 0, 32'd0,        0, 0, 0));
    vecs.push_back(mk(1, 1, 2, 6, 1, 32'hB000_0000, 32'd11,       32'd22,       0, 0, 32'd0,        0, 0, 0));
    vecs.push_back(mk(1, 1, 2, 6, 1, 32'hB000_0000, 32'd11,       32'd22,       0, 0, 32'd0,        0, 0, 0));
    vecs.push_back(mk(1, 1, 2, 6, 1, 32'hB000_0000, 32'd11,       32'd22,       0, 0, 32'd0,        1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'hC000_0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'd0,        1, 0, 1)); // x0 source and dest
    vecs.push_back(mk(1, 0, 0, 5, 1, 32'hD000_0000, 32'd0,        32'd0,        0, 0, 32'd0,        1, 0, 1)); // mark x5 busy
    vecs.push_back(mk(1, 0, 0, 5, 1, 32'hE000_0000, 32'd0,        32'd0,        0, 0, 32'd0,        1, 0, 0)); // WAW stall
    vecs.push_back(mk(1, 5, 0, 5, 1, 32'hE000_0000, 32'h0BAD,     32'd0,        1, 5, 32'h55,       1, 0, 1)); // set/clear collision
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'd0,         32'd0,        32'd0,        1, 9, 32'h99,       1, 0, 1)); // harmless writeback
    vecs.push_back(mk(1, 0, 0, 7, 0, 32'hF000_0000, 32'h33,       32'd0,        1, 0, 32'h77,       1, 0, 1)); // wb to x0
    vecs.push_back(mk(1, 0, 0, 3, 1, 32'hF000_0001, 32'd0,        32'd0,        1, 4, 32'h44,       1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'd0,         32'd0,        32'd0,        1, 6, 32'h66,       0, 0, 0)); // busy = 0x28
    vecs.push_back(mk(1, 0, 0, 8, 1, 32'hF000_0002, 32'd0,        32'd0,        1, 3, 32'h33,       0, 1, 0)); // flush
    vecs.push_back(mk(1, 3, 5, 3, 1, 32'hF000_0003, 32'h31,       32'h52,       0, 0, 32'd0,        0, 0, 1)); // busy gone
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'd0,         32'd0,        32'd0,        0, 0, 32'd0,        0, 0, 0)); // held
    vecs.push_back(mk(1, 3, 0, 3, 1, 32'h1111_0000, 32'h42,       32'd0,        0, 0, 32'd0,        1, 0, 1)); // first after reset
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'd0,         32'd0,        32'd0,        0, 0, 32'd0,        1, 0, 1));

    rstN          = 1'b0;
    flush         = 1'b0;
    rr.decValid   = 1'b0;
    rr.decRs1     = 5'd0;
    rr.decRs2     = 5'd0;
    rr.decRd      = 5'd0;
    rr.decRdWrite = 1'b0;
    rr.decPayload = 32'd0;
    rr.exReady    = 1'b0;
    regReadValue1 = 32'd0;
    regReadValue2 = 32'd0;
    wbWriteEnable = 1'b0;
    wbWriteAddr   = 5'd0;
    wbWriteValue  = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_exValid", {31'd0, rr.exValid}, 32'd0);
    chk("reset_exRs1Value", rr.exRs1Value, 32'd0);
    chk("reset_exRs2Value", rr.exRs2Value, 32'd0);
    chk("reset_exRd", {27'd0, rr.exRd}, 32'd0);
    chk("reset_exRdWrite", {31'd0, rr.exRdWrite}, 32'd0);
    chk("reset_exPayload", rr.exPayload, 32'd0);
    chk("reset_busy", dut.busy_q, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 20; i++) apply(vecs[i], 1'b0);

    // asynchronous reset while an instruction is held in the output register
    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    chk("midreset_exValid", {31'd0, rr.exValid}, 32'd0);
    chk("midreset_exRs1Value", rr.exRs1Value, 32'd0);
    chk("midreset_exPayload", rr.exPayload, 32'd0);
    chk("midreset_exRdWrite", {31'd0, rr.exRdWrite}, 32'd0);
    chk("midreset_busy", dut.busy_q, 32'd0);
    sb.delete();
    m_busy = 32'd0;
    m_exv  = 1'b0;

    apply(vecs[20], 1'b1);
    apply(vecs[21], 1'b0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
